// File: rtl/mips_pipeline_cpu.sv
// ---------------------------------------------------------------------------
// mips_pipeline_cpu
//   Five-stage (IF/ID/EX/MEM/WB) 32-bit MIPS subset CPU with an internal
//   instruction ROM, data RAM and register file.
//   Supported: add, sub, and, or, slt, addi, lw, sw, beq. Other encodings are
//   treated as NOPs.
//   Hazards: EX-stage forwarding (EX/MEM over MEM/WB), single-cycle load-use
//   stall, and beq resolved in EX with a two-slot flush.
//
// Ports
//   clk : system clock, every state update on the rising edge
//   rst : synchronous active-high reset
//
// mips_regfile
//   32 x 32-bit register file with two asynchronous read ports and one
//   clocked write port.
//   $0 is hard-wired to zero.
//   A read of the register being written this cycle returns the write data.
// ---------------------------------------------------------------------------
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);
    logic [31:0] registers [0:31];

    // Write port; $0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            registers[i_waddr] <= i_wdata;
        end
    end

    // Read ports; $0 reads zero and a same-cycle write is bypassed to the reader
    always_comb begin
        o_rdata1 = 32'd0;
        o_rdata2 = 32'd0;
        if (i_raddr1 == 5'd0)                     o_rdata1 = 32'd0;
        else if (i_we && (i_waddr == i_raddr1))   o_rdata1 = i_wdata;
        else                                      o_rdata1 = registers[i_raddr1];
        if (i_raddr2 == 5'd0)                     o_rdata2 = 32'd0;
        else if (i_we && (i_waddr == i_raddr2))   o_rdata2 = i_wdata;
        else                                      o_rdata2 = registers[i_raddr2];
    end
endmodule

module mips_pipeline_cpu #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic clk,
    input  logic rst
);
    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_ADDI  = 6'h08;
    localparam logic [5:0]  OP_LW    = 6'h23;
    localparam logic [5:0]  OP_SW    = 6'h2B;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  F_ADD    = 6'h20;
    localparam logic [5:0]  F_SUB    = 6'h22;
    localparam logic [5:0]  F_AND    = 6'h24;
    localparam logic [5:0]  F_OR     = 6'h25;
    localparam logic [5:0]  F_SLT    = 6'h2A;
    localparam logic [2:0]  ALU_ADD  = 3'd0;
    localparam logic [2:0]  ALU_SUB  = 3'd1;
    localparam logic [2:0]  ALU_AND  = 3'd2;
    localparam logic [2:0]  ALU_OR   = 3'd3;
    localparam logic [2:0]  ALU_SLT  = 3'd4;
    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_DEPTH * 4);

    // Fixed program; every word not listed here is a NOP
    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        case (idx)
            6'd0:    rom_word = 32'h2009_0005;  // addi $t1,$0,5
            6'd1:    rom_word = 32'h200A_000A;  // addi $t2,$0,10
            6'd2:    rom_word = 32'h012A_4020;  // add  $t0,$t1,$t2
            6'd3:    rom_word = 32'h0109_5822;  // sub  $t3,$t0,$t1
            6'd4:    rom_word = 32'hAC08_0000;  // sw   $t0,0($0)
            6'd5:    rom_word = 32'h8C0C_0000;  // lw   $t4,0($0)
            6'd6:    rom_word = 32'h018C_6820;  // add  $t5,$t4,$t4
            6'd7:    rom_word = 32'h1000_FFFF;  // beq  $0,$0,-1
            default: rom_word = 32'h0000_0000;
        endcase
    endfunction

    // ---------------- IF ----------------
    logic [31:0] pc_reg;
    logic [31:0] if_id_instruction;
    logic [31:0] r_if_id_pc_plus4;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_fetch_instr;

    assign w_pc_plus4    = pc_reg + 32'd4;
    assign w_fetch_instr = (pc_reg < IMEM_BYTES) ? rom_word(pc_reg[7:2]) : 32'd0;

    // ---------------- ID ----------------
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] w_imm;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;
    logic        w_reg_write, w_reg_dst, w_alu_src, w_mem_read;
    logic        w_mem_write, w_mem_to_reg, w_branch, w_uses_rt;
    logic [2:0]  w_alu_ctrl;

    assign w_opcode = if_id_instruction[31:26];
    assign rs       = if_id_instruction[25:21];
    assign rt       = if_id_instruction[20:16];
    assign rd       = if_id_instruction[15:11];
    assign w_funct  = if_id_instruction[5:0];
    assign w_imm    = {{16{if_id_instruction[15]}}, if_id_instruction[15:0]};

    // ---------------- ID/EX ----------------
    logic [31:0] id_ex_read_data1, id_ex_read_data2;
    logic [31:0] r_id_ex_pc_plus4, r_id_ex_imm;
    logic [4:0]  r_id_ex_rs, r_id_ex_rt, r_id_ex_write_reg;
    logic        r_id_ex_reg_write, r_id_ex_alu_src, r_id_ex_mem_read;
    logic        r_id_ex_mem_write, r_id_ex_mem_to_reg, r_id_ex_branch;
    logic [2:0]  r_id_ex_alu_ctrl;

    // ---------------- EX ----------------
    logic [31:0] w_fwd_a, w_fwd_b, alu_operand2, alu_result, w_branch_target;
    logic        branch, flush, stall;

    // ---------------- EX/MEM ----------------
    logic [31:0] r_ex_mem_alu_result, r_ex_mem_write_data;
    logic [4:0]  r_ex_mem_write_reg;
    logic        r_ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, r_ex_mem_mem_to_reg;

    // ---------------- MEM ----------------
    logic [31:0] r_dmem [0:DMEM_DEPTH-1];
    logic [5:0]  w_dmem_idx;
    logic [31:0] mem_data;

    assign w_dmem_idx = r_ex_mem_alu_result[7:2];
    assign mem_data   = r_dmem[w_dmem_idx];

    // ---------------- MEM/WB ----------------
    logic [31:0] r_mem_wb_alu_result, r_mem_wb_mem_data, write_data_wb;
    logic [4:0]  mem_wb_write_reg;
    logic        mem_wb_reg_write, r_mem_wb_mem_to_reg;

    assign write_data_wb = r_mem_wb_mem_to_reg ? r_mem_wb_mem_data : r_mem_wb_alu_result;

    // Shamt and the address bits outside the RAM word index are not used
    logic w_unused_bits;
    assign w_unused_bits = ^{if_id_instruction[10:6], r_ex_mem_alu_result[31:8],
                             r_ex_mem_alu_result[1:0]};

    mips_regfile rf (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (rs),
        .i_raddr2 (rt),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (mem_wb_reg_write),
        .i_waddr  (mem_wb_write_reg),
        .i_wdata  (write_data_wb)
    );

    // Instruction decode into control bits; unknown encodings leave all controls low
    always_comb begin
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_branch     = 1'b0;
        w_uses_rt    = 1'b0;
        w_alu_ctrl   = ALU_ADD;
        case (w_opcode)
            OP_RTYPE: begin
                w_uses_rt = 1'b1;
                case (w_funct)
                    F_ADD:   begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_ctrl = ALU_ADD; end
                    F_SUB:   begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_ctrl = ALU_SUB; end
                    F_AND:   begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_ctrl = ALU_AND; end
                    F_OR:    begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_ctrl = ALU_OR;  end
                    F_SLT:   begin w_reg_write = 1'b1; w_reg_dst = 1'b1; w_alu_ctrl = ALU_SLT; end
                    default: begin w_reg_write = 1'b0; end
                endcase
            end
            OP_ADDI: begin w_reg_write = 1'b1; w_alu_src = 1'b1; end
            OP_LW:   begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_mem_read = 1'b1; w_mem_to_reg = 1'b1; end
            OP_SW:   begin w_alu_src = 1'b1; w_mem_write = 1'b1; w_uses_rt = 1'b1; end
            OP_BEQ:  begin w_branch = 1'b1; w_uses_rt = 1'b1; w_alu_ctrl = ALU_SUB; end
            default: begin w_reg_write = 1'b0; end
        endcase
    end

    // Load-use detection: the loaded value is not forwardable until it leaves MEM
    always_comb begin
        if (r_id_ex_mem_read && ((r_id_ex_rt == rs) || (w_uses_rt && (r_id_ex_rt == rt))))
            stall = 1'b1;
        else
            stall = 1'b0;
    end

    // Operand forwarding; the younger EX/MEM result takes priority over MEM/WB
    always_comb begin
        if (r_ex_mem_reg_write && (r_ex_mem_write_reg != 5'd0) && (r_ex_mem_write_reg == r_id_ex_rs))
            w_fwd_a = r_ex_mem_alu_result;
        else if (mem_wb_reg_write && (mem_wb_write_reg != 5'd0) && (mem_wb_write_reg == r_id_ex_rs))
            w_fwd_a = write_data_wb;
        else
            w_fwd_a = id_ex_read_data1;
        if (r_ex_mem_reg_write && (r_ex_mem_write_reg != 5'd0) && (r_ex_mem_write_reg == r_id_ex_rt))
            w_fwd_b = r_ex_mem_alu_result;
        else if (mem_wb_reg_write && (mem_wb_write_reg != 5'd0) && (mem_wb_write_reg == r_id_ex_rt))
            w_fwd_b = write_data_wb;
        else
            w_fwd_b = id_ex_read_data2;
    end

    assign alu_operand2    = r_id_ex_alu_src ? r_id_ex_imm : w_fwd_b;
    assign w_branch_target = r_id_ex_pc_plus4 + {r_id_ex_imm[29:0], 2'b00};
    assign branch          = r_id_ex_branch && (w_fwd_a == w_fwd_b);
    assign flush           = branch;

    // ALU; arithmetic wraps, slt compares signed
    always_comb begin
        case (r_id_ex_alu_ctrl)
            ALU_ADD: alu_result = w_fwd_a + alu_operand2;
            ALU_SUB: alu_result = w_fwd_a - alu_operand2;
            ALU_AND: alu_result = w_fwd_a & alu_operand2;
            ALU_OR:  alu_result = w_fwd_a | alu_operand2;
            ALU_SLT: alu_result = {31'd0, ($signed(w_fwd_a) < $signed(alu_operand2))};
            default: alu_result = w_fwd_a + alu_operand2;
        endcase
    end

    // PC and IF/ID; a taken branch overrides a coincident stall
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg            <= 32'd0;
            if_id_instruction <= 32'd0;
            r_if_id_pc_plus4  <= 32'd0;
        end else if (branch) begin
            pc_reg            <= w_branch_target;
            if_id_instruction <= 32'd0;
            r_if_id_pc_plus4  <= 32'd0;
        end else if (stall) begin
            pc_reg            <= pc_reg;
            if_id_instruction <= if_id_instruction;
            r_if_id_pc_plus4  <= r_if_id_pc_plus4;
        end else begin
            pc_reg            <= w_pc_plus4;
            if_id_instruction <= w_fetch_instr;
            r_if_id_pc_plus4  <= w_pc_plus4;
        end
    end

    // ID/EX register; bubbled on reset, flush or load-use stall
    always_ff @(posedge clk) begin
        if (rst || branch || stall) begin
            id_ex_read_data1   <= 32'd0;
            id_ex_read_data2   <= 32'd0;
            r_id_ex_pc_plus4   <= 32'd0;
            r_id_ex_imm        <= 32'd0;
            r_id_ex_rs         <= 5'd0;
            r_id_ex_rt         <= 5'd0;
            r_id_ex_write_reg  <= 5'd0;
            r_id_ex_reg_write  <= 1'b0;
            r_id_ex_alu_src    <= 1'b0;
            r_id_ex_mem_read   <= 1'b0;
            r_id_ex_mem_write  <= 1'b0;
            r_id_ex_mem_to_reg <= 1'b0;
            r_id_ex_branch     <= 1'b0;
            r_id_ex_alu_ctrl   <= ALU_ADD;
        end else begin
            id_ex_read_data1   <= w_rdata1;
            id_ex_read_data2   <= w_rdata2;
            r_id_ex_pc_plus4   <= r_if_id_pc_plus4;
            r_id_ex_imm        <= w_imm;
            r_id_ex_rs         <= rs;
            r_id_ex_rt         <= rt;
            r_id_ex_write_reg  <= w_reg_dst ? rd : rt;
            r_id_ex_reg_write  <= w_reg_write;
            r_id_ex_alu_src    <= w_alu_src;
            r_id_ex_mem_read   <= w_mem_read;
            r_id_ex_mem_write  <= w_mem_write;
            r_id_ex_mem_to_reg <= w_mem_to_reg;
            r_id_ex_branch     <= w_branch;
            r_id_ex_alu_ctrl   <= w_alu_ctrl;
        end
    end

    // EX/MEM register; store data is the forwarded rt value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_mem_alu_result <= 32'd0;
            r_ex_mem_write_data <= 32'd0;
            r_ex_mem_write_reg  <= 5'd0;
            r_ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_read     <= 1'b0;
            ex_mem_mem_write    <= 1'b0;
            r_ex_mem_mem_to_reg <= 1'b0;
        end else begin
            r_ex_mem_alu_result <= alu_result;
            r_ex_mem_write_data <= w_fwd_b;
            r_ex_mem_write_reg  <= r_id_ex_write_reg;
            r_ex_mem_reg_write  <= r_id_ex_reg_write;
            ex_mem_mem_read     <= r_id_ex_mem_read;
            ex_mem_mem_write    <= r_id_ex_mem_write;
            r_ex_mem_mem_to_reg <= r_id_ex_mem_to_reg;
        end
    end

    // Data RAM write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= 32'd0;
        end else if (ex_mem_mem_write) begin
            r_dmem[w_dmem_idx] <= r_ex_mem_write_data;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_wb_alu_result <= 32'd0;
            r_mem_wb_mem_data   <= 32'd0;
            mem_wb_write_reg    <= 5'd0;
            mem_wb_reg_write    <= 1'b0;
            r_mem_wb_mem_to_reg <= 1'b0;
        end else begin
            r_mem_wb_alu_result <= r_ex_mem_alu_result;
            r_mem_wb_mem_data   <= mem_data;
            mem_wb_write_reg    <= r_ex_mem_write_reg;
            mem_wb_reg_write    <= r_ex_mem_reg_write;
            r_mem_wb_mem_to_reg <= r_ex_mem_mem_to_reg;
        end
    end
endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// Scoreboard bench for mips_pipeline_cpu: expected per-cycle pipeline state,
// register write-backs and data-RAM stores are queued when the program run is
// started; independent monitors pop and compare as the CPU produces them.
module tb_mips_pipeline_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mips_pipeline_cpu dut (.clk(clk), .rst(rst));

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        branch;
        logic        flush;
        logic        mw;
        logic        mr;
        logic        alu_chk;
        logic [31:0] alu;
        logic        md_chk;
        logic [31:0] md;
    } trace_t;
    typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } st_t;

    trace_t trace_q[$];
    wr_t    wr_q[$];
    st_t    st_q[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue everything one program run from reset should produce
    task automatic push_run();
        logic [31:0] pcs [17];
        trace_t t;
        pcs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                32'h1C, 32'h20, 32'h24, 32'h1C, 32'h20, 32'h24, 32'h1C, 32'h20, 32'h24};
        for (int k = 0; k < 17; k++) begin
            t.pc      = pcs[k];
            t.stall   = (k == 7);
            t.branch  = (k == 10) || (k == 13) || (k == 16);
            t.flush   = t.branch;
            t.mw      = (k == 7);
            t.mr      = (k == 8);
            t.alu_chk = (k == 4) || (k == 9);
            t.alu     = (k == 4) ? 32'h0000_000F : 32'h0000_001E;
            t.md_chk  = (k == 8);
            t.md      = 32'h0000_000F;
            trace_q.push_back(t);
        end
        wr_q.push_back('{5'd9,  32'h0000_0005});
        wr_q.push_back('{5'd10, 32'h0000_000A});
        wr_q.push_back('{5'd8,  32'h0000_000F});
        wr_q.push_back('{5'd11, 32'h0000_000A});
        wr_q.push_back('{5'd12, 32'h0000_000F});
        wr_q.push_back('{5'd13, 32'h0000_001E});
        st_q.push_back('{32'h0000_0000, 32'h0000_000F});
    endtask

    task automatic check_reset_state(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.rf.registers[i] !== 32'd0) nz++;
        chk({tag, "_pc"},        dut.pc_reg, 32'd0);
        chk({tag, "_if_id"},     dut.if_id_instruction, 32'd0);
        chk({tag, "_id_ex_rd1"}, dut.id_ex_read_data1, 32'd0);
        chk({tag, "_wb_we"},     {31'd0, dut.mem_wb_reg_write}, 32'd0);
        chk({tag, "_nonzero_regs"}, 32'(nz), 32'd0);
        chk({tag, "_dmem0"},     dut.r_dmem[0], 32'd0);
    endtask

    task automatic check_run_end(input string tag);
        chk({tag, "_trace_left"}, 32'(trace_q.size()), 32'd0);
        chk({tag, "_wb_left"},    32'(wr_q.size()), 32'd0);
        chk({tag, "_st_left"},    32'(st_q.size()), 32'd0);
        chk({tag, "_r8"},  dut.rf.registers[8],  32'h0000_000F);
        chk({tag, "_r9"},  dut.rf.registers[9],  32'h0000_0005);
        chk({tag, "_r10"}, dut.rf.registers[10], 32'h0000_000A);
        chk({tag, "_r11"}, dut.rf.registers[11], 32'h0000_000A);
        chk({tag, "_r12"}, dut.rf.registers[12], 32'h0000_000F);
        chk({tag, "_r13"}, dut.rf.registers[13], 32'h0000_001E);
        chk({tag, "_r0"},  dut.rf.registers[0],  32'd0);
        chk({tag, "_dmem0"}, dut.r_dmem[0], 32'h0000_000F);
    endtask

    // Per-cycle pipeline trace monitor
    trace_t mt;
    always @(negedge clk) begin
        if (!rst && (trace_q.size() > 0)) begin
            mt = trace_q.pop_front();
            chk("pc",     dut.pc_reg, mt.pc);
            chk("stall",  {31'd0, dut.stall},  {31'd0, mt.stall});
            chk("branch", {31'd0, dut.branch}, {31'd0, mt.branch});
            chk("flush",  {31'd0, dut.flush},  {31'd0, mt.flush});
            chk("mem_write", {31'd0, dut.ex_mem_mem_write}, {31'd0, mt.mw});
            chk("mem_read",  {31'd0, dut.ex_mem_mem_read},  {31'd0, mt.mr});
            if (mt.alu_chk) chk("alu_result", dut.alu_result, mt.alu);
            if (mt.md_chk)  chk("mem_data",   dut.mem_data,   mt.md);
        end
    end

    // Register write-back monitor
    wr_t mw;
    always @(negedge clk) begin
        if (!rst && dut.mem_wb_reg_write && (dut.mem_wb_write_reg != 5'd0)) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb actual=r%0d/%h expected=none", dut.mem_wb_write_reg, dut.write_data_wb);
            end else begin
                mw = wr_q.pop_front();
                chk("wb_reg",  {27'd0, dut.mem_wb_write_reg}, {27'd0, mw.r});
                chk("wb_data", dut.write_data_wb, mw.d);
            end
        end
    end

    // Data-RAM store monitor
    st_t ms;
    always @(negedge clk) begin
        if (!rst && dut.ex_mem_mem_write) begin
            if (st_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_store actual=%h/%h expected=none", dut.r_ex_mem_alu_result, dut.r_ex_mem_write_data);
            end else begin
                ms = st_q.pop_front();
                chk("st_addr", dut.r_ex_mem_alu_result, ms.a);
                chk("st_data", dut.r_ex_mem_write_data, ms.d);
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        push_run();
        rst = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check_run_end("run1");

        // Reset in the middle of the branch loop, then re-run the program
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midreset");
        push_run();
        rst = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check_run_end("run2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
